// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared BCD digit type, constants and FSM states for score_bank
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_COMMIT
    } state_t;

    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - one-digit BCD adder with carry in and carry out
module bcd_digit_add
    import score_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout = (raw > 5'd9);
        s    = cout ? 4'(raw - 5'd10) : raw[3:0];
    end

endmodule

// File: rtl/score_bank.sv
// rtl/score_bank.sv - multi-channel BCD score accumulator with request FIFO and hiscore tracking
module score_bank
    import score_pkg::*;
#(
    parameter int  DIGITS     = 6,
    parameter int  PLAYERS    = 2,
    parameter int  FIFO_DEPTH = 4,
    localparam int PW         = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        add_valid,
    output logic                        add_ready,
    input  logic [PW-1:0]               add_player,
    input  logic [DIGITS*4-1:0]         add_value,
    input  logic                        clr,
    input  logic [PW-1:0]               clr_player,
    output logic [PLAYERS*DIGITS*4-1:0] score,
    output logic [DIGITS*4-1:0]         hiscore,
    output logic                        new_hiscore,
    output logic                        overflow,
    output logic                        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DIGITS);

    typedef bcd_digit_t [DIGITS-1:0] word_t;

    state_t               state_q, state_d;
    word_t                work_q, work_d;
    word_t                cur_value_q, cur_value_d;
    word_t                hiscore_q, hiscore_d;
    word_t [PLAYERS-1:0]  score_q, score_d;
    logic                 carry_q, carry_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        cur_player_q, cur_player_d;
    logic                 new_hiscore_q, new_hiscore_d;
    logic                 overflow_q, overflow_d;
    logic [PW-1:0]        fifo_player_q [FIFO_DEPTH];
    logic [PW-1:0]        fifo_player_d [FIFO_DEPTH];
    word_t                fifo_value_q [FIFO_DEPTH];
    word_t                fifo_value_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic       push, pop, clr_ok, clr_hit, sum_carry;
    word_t      clamped, result;
    bcd_digit_t sum_digit;

    function automatic logic player_ok(input logic [PW-1:0] p);
        return int'(p) < PLAYERS;
    endfunction

    bcd_digit_add u_digit_add (
        .a    (work_q[idx_q]),
        .b    (cur_value_q[idx_q]),
        .cin  (carry_q),
        .s    (sum_digit),
        .cout (sum_carry)
    );

    assign add_ready   = (count_q != CW'(FIFO_DEPTH));
    assign busy        = (state_q != ST_IDLE) || (count_q != '0);
    assign score       = score_q;
    assign hiscore     = hiscore_q;
    assign new_hiscore = new_hiscore_q;
    assign overflow    = overflow_q;

    always_comb begin
        clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            clamped[i] = clamp_digit(add_value[i*4 +: 4]);
        end
    end

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        cur_value_d   = cur_value_q;
        hiscore_d     = hiscore_q;
        score_d       = score_q;
        carry_d       = carry_q;
        idx_d         = idx_q;
        cur_player_d  = cur_player_q;
        new_hiscore_d = 1'b0;
        overflow_d    = 1'b0;
        fifo_player_d = fifo_player_q;
        fifo_value_d  = fifo_value_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        result        = work_q;
        pop           = 1'b0;
        push          = add_valid && add_ready;
        clr_ok        = clr && player_ok(clr_player);
        clr_hit       = clr_ok && (clr_player == cur_player_q);

        if (push) begin
            fifo_player_d[wr_ptr_q] = add_player;
            fifo_value_d[wr_ptr_q]  = clamped;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    // Out-of-range channels are consumed here and never reach ADD.
                    if (player_ok(fifo_player_q[rd_ptr_q])) begin
                        state_d      = ST_ADD;
                        cur_player_d = fifo_player_q[rd_ptr_q];
                        cur_value_d  = fifo_value_q[rd_ptr_q];
                        work_d       = score_q[fifo_player_q[rd_ptr_q]];
                        carry_d      = 1'b0;
                        idx_d        = '0;
                    end
                end
            end
            ST_ADD: begin
                work_d[idx_q] = sum_digit;
                carry_d       = sum_carry;
                idx_d         = idx_q + 1'b1;
                if (idx_q == IW'(DIGITS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (carry_q) begin
                    result = {DIGITS{BCD_MAX}};
                end
                if (!clr_hit) begin
                    score_d[cur_player_q] = result;
                    overflow_d            = carry_q;
                    if (result > hiscore_q) begin
                        hiscore_d     = result;
                        new_hiscore_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Applied last so a clear overrides a same-edge commit to that channel.
        if (clr_ok) begin
            score_d[clr_player] = '0;
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            work_q        <= '0;
            cur_value_q   <= '0;
            hiscore_q     <= '0;
            score_q       <= '0;
            carry_q       <= 1'b0;
            idx_q         <= '0;
            cur_player_q  <= '0;
            new_hiscore_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_player_q[i] <= '0;
                fifo_value_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            cur_value_q   <= cur_value_d;
            hiscore_q     <= hiscore_d;
            score_q       <= score_d;
            carry_q       <= carry_d;
            idx_q         <= idx_d;
            cur_player_q  <= cur_player_d;
            new_hiscore_q <= new_hiscore_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fifo_player_q <= fifo_player_d;
            fifo_value_q  <= fifo_value_d;
        end
    end

endmodule

// File: tb/tb_score_bank.sv
// tb/tb_score_bank.sv - table, corner-case sequences and random model checks for score_bank
`timescale 1ns/1ps
module tb_score_bank;

    localparam int DIGITS = 4;
    localparam int PW     = 1;
    localparam int BPW    = 2;

    logic        clk = 1'b0;
    logic        resetN;
    logic        add_valid, add_ready, clr, new_hiscore, overflow, busy;
    logic [PW-1:0] add_player, clr_player;
    logic [15:0] add_value, hiscore;
    logic [31:0] score;

    logic        b_add_valid, b_add_ready, b_clr, b_new_hiscore, b_overflow, b_busy;
    logic [BPW-1:0] b_add_player, b_clr_player;
    logic [15:0] b_add_value, b_hiscore;
    logic [47:0] b_score;

    always #5 clk = ~clk;

    score_bank #(.DIGITS(4), .PLAYERS(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetN(resetN), .add_valid(add_valid), .add_ready(add_ready),
        .add_player(add_player), .add_value(add_value), .clr(clr), .clr_player(clr_player),
        .score(score), .hiscore(hiscore), .new_hiscore(new_hiscore), .overflow(overflow), .busy(busy)
    );

    score_bank #(.DIGITS(4), .PLAYERS(3), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .resetN(resetN), .add_valid(b_add_valid), .add_ready(b_add_ready),
        .add_player(b_add_player), .add_value(b_add_value), .clr(b_clr), .clr_player(b_clr_player),
        .score(b_score), .hiscore(b_hiscore), .new_hiscore(b_new_hiscore), .overflow(b_overflow), .busy(b_busy)
    );

    int total = 0;
    int bad   = 0;
    int ovf_cnt = 0, nh_cnt = 0, b_ovf_cnt = 0, b_nh_cnt = 0;

    always @(negedge clk) begin
        if (overflow)      ovf_cnt   <= ovf_cnt + 1;
        if (new_hiscore)   nh_cnt    <= nh_cnt + 1;
        if (b_overflow)    b_ovf_cnt <= b_ovf_cnt + 1;
        if (b_new_hiscore) b_nh_cnt  <= b_nh_cnt + 1;
    end

    typedef struct {
        int          player;
        int          ch;
        logic [15:0] value;
        logic [15:0] exp_score;
        int          exp_ovf;
        int          exp_nh;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vecs [6];

    int m_score [2];
    int m_hi, m_ovf, m_nh;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sc(input int ch);
        return score[ch*16 +: 16];
    endfunction

    function automatic logic [15:0] b_sc(input int ch);
        return b_score[ch*16 +: 16];
    endfunction

    function automatic int bcd_val(input logic [15:0] v);
        int r;
        int d;
        r = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(v[i*4 +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_apply(input int p, input logic [15:0] v);
        int s;
        s = m_score[p] + bcd_val(v);
        if (s > 9999) begin
            s = 9999;
            m_ovf++;
        end
        m_score[p] = s;
        if (s > m_hi) begin
            m_hi = s;
            m_nh++;
        end
    endtask

    // Called and returns at 1ns after a rising edge; the request is accepted on the edge in between.
    task automatic do_add(input int player, input logic [15:0] val);
        int n;
        n = 0;
        add_player = PW'(player);
        add_value  = val;
        add_valid  = 1'b1;
        while (!add_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        add_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit which);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (!(which ? b_busy : busy)) break;
            n++;
        end
        @(posedge clk); #1;
        check(which ? "b idle" : "idle", which ? b_busy : busy, 1'b0);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, n0, lat, acc;
        bit saw_full;
        logic [15:0] rv;

        vecs[0] = '{0, 0, 16'h0123, 16'h0123, 0, 1, 16'h0123};
        vecs[1] = '{0, 0, 16'h9867, 16'h9990, 0, 1, 16'h9990};
        vecs[2] = '{0, 0, 16'h0015, 16'h9999, 1, 1, 16'h9999};
        vecs[3] = '{1, 1, 16'h00AF, 16'h0099, 0, 0, 16'h9999};
        vecs[4] = '{3, 1, 16'h0905, 16'h1004, 0, 0, 16'h9999};
        vecs[5] = '{1, 1, 16'h9999, 16'h9999, 1, 0, 16'h9999};

        add_valid = 0; add_player = '0; add_value = '0; clr = 0; clr_player = '0;
        b_add_valid = 0; b_add_player = '0; b_add_value = '0; b_clr = 0; b_clr_player = '0;
        resetN = 1'b0;
        #23;
        check("reset score", score, 32'h0);
        check("reset hiscore", hiscore, 16'h0);
        check("reset add_ready", add_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            o0 = ovf_cnt;
            n0 = nh_cnt;
            do_add(vecs[i].player, vecs[i].value);
            lat = 0;
            while (sc(vecs[i].ch) !== vecs[i].exp_score && lat < 30) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("vec%0d latency", i), lat, DIGITS + 2);
            wait_idle(0);
            check($sformatf("vec%0d score", i), sc(vecs[i].ch), vecs[i].exp_score);
            check($sformatf("vec%0d overflow pulses", i), ovf_cnt - o0, vecs[i].exp_ovf);
            check($sformatf("vec%0d new_hiscore pulses", i), nh_cnt - n0, vecs[i].exp_nh);
            check($sformatf("vec%0d hiscore", i), hiscore, vecs[i].exp_hi);
        end

        clr = 1'b1; clr_player = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr p1 score", sc(1), 16'h0);
        check("clr keeps p0", sc(0), 16'h9999);
        check("clr keeps hiscore", hiscore, 16'h9999);

        o0 = ovf_cnt;
        acc = 0;
        saw_full = 0;
        add_valid = 1'b1; add_player = 1'b1; add_value = 16'h0001;
        for (int c = 0; c < 300 && acc < 8; c++) begin
            @(negedge clk);
            if (add_ready) acc++;
            else saw_full = 1;
            @(posedge clk); #1;
        end
        add_valid = 1'b0;
        wait_idle(0);
        check("burst accepted", acc, 8);
        check("burst saw full", saw_full, 1'b1);
        check("burst score p1", sc(1), 16'h0008);
        check("burst no overflow", ovf_cnt - o0, 0);

        b_add_player = 2'd3; b_add_value = 16'h0123; b_add_valid = 1'b1;
        @(posedge clk); #1;
        b_add_valid = 1'b0;
        wait_idle(1);
        check("b drop scores", b_score, 48'h0);
        check("b drop hiscore", b_hiscore, 16'h0);
        check("b drop pulses", b_nh_cnt + b_ovf_cnt, 0);
        b_add_player = 2'd2; b_add_value = 16'h00AF; b_add_valid = 1'b1;
        @(posedge clk); #1;
        b_add_valid = 1'b0;
        wait_idle(1);
        check("b p2 clamp", b_sc(2), 16'h0099);
        check("b p2 hiscore", b_hiscore, 16'h0099);
        check("b p0 p1 untouched", b_score[31:0], 32'h0);

        do_add(0, 16'h0500);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetN = 1'b0;
        #1;
        check("midreset score", score, 32'h0);
        check("midreset hiscore", hiscore, 16'h0);
        check("midreset add_ready", add_ready, 1'b1);
        check("midreset busy", busy, 1'b0);
        check("midreset pulses", {new_hiscore, overflow}, 2'b00);
        @(negedge clk);
        resetN = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        check("midreset no commit", score, 32'h0);
        do_add(0, 16'h0005);
        wait_idle(0);
        check("after reset add", sc(0), 16'h0005);
        check("after reset hiscore", hiscore, 16'h0005);

        o0 = ovf_cnt;
        n0 = nh_cnt;
        do_add(1, 16'h0100);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        clr = 1'b1; clr_player = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        wait_idle(0);
        check("collide score p1", sc(1), 16'h0);
        check("collide pulses", (ovf_cnt - o0) + (nh_cnt - n0), 0);
        check("collide hiscore", hiscore, 16'h0005);

        clr = 1'b1; clr_player = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr p0 score", sc(0), 16'h0);
        check("clr p0 hiscore", hiscore, 16'h0005);

        do_reset();
        m_score[0] = 0; m_score[1] = 0; m_hi = 0; m_ovf = 0; m_nh = 0;
        o0 = ovf_cnt;
        n0 = nh_cnt;
        for (int c = 0; c < 400; c++) begin
            add_valid  = ($urandom_range(0, 2) != 0);
            add_player = PW'($urandom_range(0, 1));
            rv = 16'($urandom);
            if ($urandom_range(0, 15) != 0) rv = rv & 16'h00FF;
            add_value = rv;
            @(negedge clk);
            if (add_valid && add_ready) model_apply(int'(add_player), add_value);
            @(posedge clk); #1;
        end
        add_valid = 1'b0;
        wait_idle(0);
        check("random score p0", sc(0), to_bcd(m_score[0]));
        check("random score p1", sc(1), to_bcd(m_score[1]));
        check("random hiscore", hiscore, to_bcd(m_hi));
        check("random overflow pulses", ovf_cnt - o0, m_ovf);
        check("random new_hiscore pulses", nh_cnt - n0, m_nh);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_bank.md
SCORE_BANK -- requirements
Module: score_bank

Interface
REQ-001 SHALL have parameter DIGITS, default 6, meaning the number of BCD digits per score (minimum 2).
REQ-002 SHALL have parameter PLAYERS, default 2, meaning the number of independent score channels (minimum 1).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of pending add requests (power of 2, minimum 2).
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port add_valid, input, 1 bit: an add request is presented.
REQ-007 SHALL have port add_ready, output, 1 bit: high while the request FIFO is not full; a request is accepted on an edge where add_valid and add_ready are both high.
REQ-008 SHALL have port add_player, input, PW = max(1, clog2(PLAYERS)) bits: the target channel.
REQ-009 SHALL have port add_value, input, DIGITS x 4 bits: the packed BCD addend, least significant digit at [0].
REQ-010 SHALL have port clr, input, 1 bit: a one-cycle request to clear the channel given on clr_player.
REQ-011 SHALL have port clr_player, input, PW bits: the channel to clear.
REQ-012 SHALL have port score, output, PLAYERS x DIGITS x 4 bits: the committed score of every channel.
REQ-013 SHALL have port hiscore, output, DIGITS x 4 bits: the highest score committed since reset.
REQ-014 SHALL have port new_hiscore, output, 1 bit: a one-cycle pulse when hiscore changes.
REQ-015 SHALL have port overflow, output, 1 bit: a one-cycle pulse when a commit saturates.
REQ-016 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE or the FIFO is not empty.

Function
REQ-017 SHALL push each accepted request {player, value} into the FIFO; add_valid while add_ready is low SHALL be ignored with no side effect.
REQ-018 SHALL clamp every add_value digit above 9 to 9 at the moment the request is accepted.
REQ-019 SHALL run the FSM states IDLE, ADD and COMMIT, with these transitions:
  - IDLE -> ADD when the FIFO is non-empty: pop one entry, load the channel's score into the working register, clear the carry and set the digit index to 0;
  - ADD: one digit per cycle, LSD first, through a BCD digit adder with carry; after digit DIGITS-1 go to COMMIT;
  - COMMIT: write the result and return to IDLE.
REQ-020 SHALL give a fixed latency for a request accepted on edge E0 with the FSM in IDLE and the FIFO empty: score is updated on edge E0+DIGITS+2.
REQ-021 SHALL, when the final carry is 1, commit all digits as 9 and pulse overflow on the commit edge.
REQ-022 SHALL, when the committed value is greater than hiscore (unsigned compare of the packed vector), load hiscore on the same edge and pulse new_hiscore; an equal or lower value SHALL change nothing.
REQ-023 SHALL clear score[clr_player] on the edge after clr is seen; clr SHALL never affect hiscore.
REQ-024 SHALL, when clr and a COMMIT hit the same channel on the same edge, let the clear win and discard the commit with no overflow or new_hiscore pulse.
REQ-025 SHALL not cancel queued or in-flight requests on a clr; requests already in ADD keep their pre-clear base value.
REQ-026 SHALL accept a request whose player index is PLAYERS or higher, then pop and drop it, returning to IDLE without a commit.
REQ-027 SHALL allow a push and a pop on the same edge; the FIFO count SHALL then be unchanged.
REQ-028 SHALL raise add_ready on the edge after a pop frees a slot, and SHALL never allow a push into a full FIFO.

Reset
REQ-029 SHALL, while resetN is low, immediately force all score digits to 0, hiscore to 0, the FIFO to empty, the FSM to IDLE, the working register and carry to 0, new_hiscore and overflow to 0, busy to 0 and add_ready to 1.
REQ-030 SHALL lose any operation in progress when reset is asserted mid-operation, with no partial commit.

Structure
REQ-031 SHALL take from package score_pkg the typedef bcd_digit_t (4 bits), the constant BCD_MAX = 4'd9 and the FSM state enum.
REQ-032 SHALL use one sub-module, bcd_digit_add: combinational, inputs a, b, cin; outputs s, cout.
REQ-033 SHALL implement the FIFO inline.

Verification
REQ-034 SHALL test, with DIGITS=4, PLAYERS=2, FIFO_DEPTH=4: after reset, add 0123 to P0 -> score[0]=0123 exactly 6 edges after acceptance; hiscore=0123; one new_hiscore pulse.
REQ-035 SHALL test: P0 at 9990, add 0015 -> score[0]=9999; one overflow pulse.
REQ-036 SHALL test: 8 back-to-back adds of 0001 to P1 -> add_ready drops while the FIFO is full, no request is lost, final score[1]=0008.
REQ-037 SHALL test: clr of P1 on the same edge as a P1 commit -> score[1]=0000, no pulses, hiscore unchanged.
REQ-038 SHALL test: add_value digits 0x00AF to P0 -> treated as 0099; an add to player index 3 (PW=1 wraps to 1) and a player index at or above PLAYERS with PLAYERS=3 -> dropped.
REQ-039 SHALL test: resetN low during ADD -> all outputs 0, add_ready=1, busy=0; the next add of 0005 -> score=0005.
